// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing six active-low hex digits between two req/ack requesters.
// Optional build macro HEXDISP_LZ_BLANK_EN enables leading-zero suppression on hex5..hex1.
module hex_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   output logic [1:0]  ack,
   output logic        busy,
   output logic        owner,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5
);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   localparam logic [31:0] CNT_LOAD = 32'(HOLD_CYCLES - 1);
   localparam logic [6:0]  BLANK    = 7'b1111111;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_rr;
   logic        r_valid;
   logic [31:0] r_disp;
   logic [1:0]  r_ack;
   logic        r_busy;
   logic        r_owner;

   logic        w_win;
   logic [6:0]  w_hex [6];
   logic        w_unused_hi;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000100;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // On a tie the requester that did not win last time takes the grant.
   always_comb begin
      w_win = (req == 2'b11) ? ~r_rr : req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rr    <= 1'b1;
         r_valid <= 1'b0;
         r_disp  <= '0;
         r_ack   <= 2'b00;
         r_busy  <= 1'b0;
         r_owner <= 1'b0;
      end else begin
         r_ack <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_disp  <= w_win ? data1 : data0;
                  r_owner <= w_win;
                  r_rr    <= w_win;
                  r_ack   <= w_win ? 2'b10 : 2'b01;
                  r_cnt   <= CNT_LOAD;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The top byte is latched with the word but never displayed.
   assign w_unused_hi = ^r_disp[31:24];

`ifdef HEXDISP_LZ_BLANK_EN
   logic w_zero_above [6];

   always_comb begin
      for (int i = 5; i >= 0; i--) begin
         if (i == 5) w_zero_above[i] = (r_disp[4*i +: 4] == 4'h0);
         else        w_zero_above[i] = w_zero_above[i+1] && (r_disp[4*i +: 4] == 4'h0);
      end
      for (int i = 0; i < 6; i++) begin
         if (!r_valid)                         w_hex[i] = BLANK;
         else if ((i != 0) && w_zero_above[i]) w_hex[i] = BLANK;
         else                                  w_hex[i] = seg7(r_disp[4*i +: 4]);
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         if (!r_valid) w_hex[i] = BLANK;
         else          w_hex[i] = seg7(r_disp[4*i +: 4]);
      end
   end
`endif

   assign ack   = r_ack;
   assign busy  = r_busy;
   assign owner = r_owner;
   assign hex0  = w_hex[0];
   assign hex1  = w_hex[1];
   assign hex2  = w_hex[2];
   assign hex3  = w_hex[3];
   assign hex4  = w_hex[4];
   assign hex5  = w_hex[5];

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the board's six seven-segment digits between two requesters, typically the CPU output port and a debug/monitor source. Each requester posts a 32-bit word with a req/ack handshake. The arbiter grants one requester at a time (round-robin) and latches its data. It decodes the low 24 bits to six active-low hex digits and holds the image for a minimum dwell time before it accepts another grant. It sits between the CPU I/O space and the hex pins and replaces direct per-digit instantiation in the output formatting path.

## Interface
Parameters:
- HOLD_CYCLES, 50_000_000, minimum dwell of a granted image, in clk cycles; legal range 1 to 2^32-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  request, one bit per requester; a requester holds its bit high until it sees its ack bit.
- data0  in  32  requester 0 word; must be stable while req[0] is high.
- data1  in  32  requester 1 word; must be stable while req[1] is high.
- ack  out  2  one-cycle grant pulse, at most one bit high in any cycle.
- busy  out  1  high while in HOLD.
- owner  out  1  index of the last granted requester.
- hex0..hex5  out  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 shows data[3:0] and hex5 shows data[23:20].

## Operation
- Two states: IDLE and HOLD.
- **IDLE, no req bit set:** stay in IDLE; the displayed image is unchanged.
- **IDLE, any req bit set:**
  - Pick the winner. If only one bit is set, that requester wins. If both are set, the requester not equal to the rr pointer's last grant wins.
  - On the next edge: latch the winner's data into disp_reg, set owner, pulse ack[winner], load cnt = HOLD_CYCLES-1, move to HOLD, and set the rr pointer to the winner.
- **HOLD:** decrement cnt each cycle. When cnt==0, move to IDLE on the next edge. req is ignored throughout HOLD.
- After HOLD ends, disp_reg keeps its image until the next grant. It does not blank.
- **Withdrawal:** a req bit dropped before its ack is not an error. That requester loses its pending request and gets no grant.
- **Decoder** (combinational from disp_reg nibbles), active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000100, F=0001110
  - blank=1111111
- disp_reg[31:24] is latched but not displayed.
- **Reset values:**
  - state=IDLE, ack=0, busy=0, owner=0, cnt=0.
  - rr pointer = 1, so requester 0 wins the first simultaneous request.
  - A valid flag is cleared; while it is clear, all hex outputs show blank.
  - The first grant sets the valid flag.

## Timing
- Grant latency: req sampled high in IDLE at edge n → at edge n+1, ack, hex outputs, owner and busy all update together.
- busy is high for exactly HOLD_CYCLES cycles per grant.
- Minimum spacing between two acks is HOLD_CYCLES+1 cycles. With HOLD_CYCLES=1, acks are 2 cycles apart.
- ack is never high on two consecutive cycles.
- Reset asserted mid-HOLD: within the same asynchronous assertion, hex goes blank, ack and busy go to 0, and a pending ack is lost. After rst_n rises, the first edge evaluates IDLE.
- A requester that keeps req high after its ack is treated as a new request at the next IDLE evaluation.

## Configuration
- HEXDISP_LZ_BLANK_EN defined: leading-zero suppression. Any digit whose own nibble and all higher displayed nibbles are zero shows blank, except hex0, which always shows its value. Example: 0x000A05 shows as "A05" on hex2..hex0, with hex5..hex3 blank.
- HEXDISP_LZ_BLANK_EN undefined: all six digits always show their nibble. Example: 0x000A05 shows as "000A05".
- Arbitration and timing are identical in both builds.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset, then req=00 for 10 cycles → all hex outputs = 1111111, ack=00, busy=0, owner=0.
- req[0]=1 with data0=0x00123456 at edge n → ack=01 at edge n+1. Display is hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010. busy is high for 4 cycles.
- req=11 held, data0=0xAAAAAA, data1=0xBBBBBB → grant order 0,1,0,1 with acks exactly 5 cycles apart. owner toggles, and hex alternates between 0001000 and 0000011 on all digits.
- req[1] raised during HOLD and dropped before HOLD ends → no ack[1]. The image is unchanged and the FSM returns to IDLE.
- rst_n pulsed low 2 cycles into HOLD → hex blanks immediately and busy=0. After release, req[0] is granted 1 cycle later.
- Build with HEXDISP_LZ_BLANK_EN, data0=0x00000000 → hex0=1000000 and hex1..hex5=1111111. Build without it → all six digits = 1000000.
